// File: rtl/icg_multi_ctrl_if.sv
// Bundle of the request, override and status signals between the clock-gating
// controller and its clients.
interface icg_multi_ctrl_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
);
  logic                    test_en;
  logic [NUM_CH-1:0]       en;
  logic                    cnt_clr;
  logic [NUM_CH-1:0]       gclk;
  logic [NUM_CH-1:0]       ch_on;
  logic [NUM_CH*CNT_W-1:0] off_cnt;

  modport master (
    output test_en, en, cnt_clr,
    input  gclk, ch_on, off_cnt
  );

  modport slave (
    input  test_en, en, cnt_clr,
    output gclk, ch_on, off_cnt
  );
endinterface

// File: rtl/icg_multi_ctrl.sv
// Multi-channel clock-gating controller: per-channel idle-hysteresis FSM, low-phase
// enable latch, scan override and saturating gate-off event counters.
module icg_multi_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned CNT_W       = 8
) (
  input logic             i_clk,
  input logic             i_rst,
  icg_multi_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StOff  = 2'b00,
    StOn   = 2'b01,
    StHold = 2'b10
  } state_e;

  // Idle counter only has to hold IDLE_CYCLES-1.
  localparam int unsigned IdleW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int unsigned IdleLoadInt = (IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1;
  localparam logic [IdleW-1:0] IdleLoad = IdleW'(IdleLoadInt);

  state_e            r_state    [NUM_CH];
  state_e            w_state_nxt[NUM_CH];
  logic [IdleW-1:0]  r_idle     [NUM_CH];
  logic [IdleW-1:0]  w_idle_nxt [NUM_CH];
  logic [CNT_W-1:0]  r_cnt      [NUM_CH];
  logic [NUM_CH-1:0] w_gate_off;
  logic [NUM_CH-1:0] w_gate_req;
  logic [NUM_CH-1:0] r_ch_on;
  logic [NUM_CH-1:0] r_enl;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_idle_nxt[i]  = r_idle[i];
      w_gate_off[i]  = 1'b0;
      case (r_state[i])
        StOff: begin
          if (bus.en[i]) w_state_nxt[i] = StOn;
        end
        StOn: begin
          if (!bus.en[i]) begin
            if (IDLE_CYCLES == 0) begin
              w_state_nxt[i] = StOff;
              w_gate_off[i]  = 1'b1;
            end else begin
              w_state_nxt[i] = StHold;
              w_idle_nxt[i]  = IdleLoad;
            end
          end
        end
        StHold: begin
          if (bus.en[i]) begin
            w_state_nxt[i] = StOn;
            w_idle_nxt[i]  = '0;
          end else if (r_idle[i] == '0) begin
            w_state_nxt[i] = StOff;
            w_gate_off[i]  = 1'b1;
          end else begin
            w_idle_nxt[i] = r_idle[i] - 1'b1;
          end
        end
        default: w_state_nxt[i] = StOff;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= StOff;
        r_idle[i]  <= '0;
        r_cnt[i]   <= '0;
      end
      r_ch_on <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_idle[i]  <= w_idle_nxt[i];
        r_ch_on[i] <= (w_state_nxt[i] != StOff);
        // Clear has priority over a coincident gate-off event.
        if (bus.cnt_clr) begin
          r_cnt[i] <= '0;
        end else if (w_gate_off[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_gate_req[i] = (r_state[i] != StOff) | bus.test_en;
    end
  end

  // Transparent only while the clock is low, so the gate cannot change mid-pulse.
  always_latch begin
    if (!i_rst) begin
      r_enl <= '0;
    end else if (!i_clk) begin
      r_enl <= w_gate_req;
    end
  end

  assign bus.gclk  = {NUM_CH{i_clk}} & r_enl;
  assign bus.ch_on = r_ch_on;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
    assign bus.off_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

endmodule
